mcpu_alu_mul_seq: RTL and testbench
===================================

Name: mcpu_alu_mul_seq

Overview:
- Multi-cycle sequencer that initiates operations on an external MCPU ALU instance: it issues ALU op words and operands, and consumes the ALU data output and flag output.
- Uses only the ALU to compute the unsigned 32x32 product, low 32 bits, by shift-and-add.
- Sits beside the ALU as the controller for the multiply micro-routine. It drives the ALU op/a/b inputs while busy; an external mux selects its drive versus the main datapath's.

Parameters:
- MAX_ITER, 32: maximum loop iterations; one multiplier bit per iteration.
- EARLY_EXIT, 1: 1 = finish as soon as the multiplier reaches zero; 0 = always run MAX_ITER iterations.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a_in  in  32  multiplicand; latched when start is accepted
- b_in  in  32  multiplier; latched when start is accepted
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the DONE state
- result  out  32  product; valid from the done cycle and held until the next accepted start
- alu_op  out  32  op word to the ALU
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_d  in  32  ALU data output (combinational response to alu_op/a/b in the same cycle)
- alu_f  in  1  ALU flag output (same cycle)

Behaviour:
- Internal registers: acc (result), mcand, mplier (all 32 bits); iter (6 bits); state.
- ALU op words (bit 4 cin=0, bit 3 inv=0, bits 6:5 bop, bits 2:0 op/test, upper bits 0):
  - CHECK: 32'h01 (AND, test B==0), alu_b = mplier.
  - SHR: 32'h45 (OP_B, bop RSHIFT, test B_LO). alu_d = mplier>>1; alu_f = mplier[0], taken from the unshifted b.
  - ADD: 32'h00 (ADD, bop B), alu_a = acc, alu_b = mcand.
  - SHL: 32'h65 (OP_B, bop LSHIFT), alu_b = mcand.
  - IDLE and DONE: alu_op, alu_a and alu_b all 0.
- alu_op/alu_a/alu_b are combinational from the state and registers. alu_d/alu_f are sampled at the rising edge ending that state.
- alu_a = 0 in every state except ADD.
- State machine:
  - IDLE: when start=1, latch mcand=a_in, mplier=b_in; clear acc=0, iter=0; go to CHECK. When start=0, stay in IDLE.
  - CHECK: if EARLY_EXIT and alu_f=1 (mplier==0), go to DONE; else go to SHR.
  - SHR: mplier <= alu_d; remember bit = alu_f; go to ADD if bit=1, else SHL.
  - ADD: acc <= alu_d (mod 2^32, carry discarded); go to SHL.
  - SHL: mcand <= alu_d (bit 31 discarded); iter <= iter+1; go to DONE if iter+1 == MAX_ITER, else CHECK.
  - DONE: done=1 for exactly one cycle; go to IDLE.
- Per-iteration cost: 4 cycles if the multiplier bit is 1, 3 cycles if 0; CHECK adds 1 final cycle on early exit; DONE is 1 cycle.
- start while busy (including in DONE) is ignored; latched operands are not disturbed.
- result = acc at all times.
- Reset, including mid-operation, immediately forces:
  - state=IDLE; acc, mcand, mplier, iter = 0;
  - busy=0, done=0, result=0, and all ALU drive outputs = 0.
- All arithmetic is unsigned and wraps mod 2^32. Overflow is not flagged.

Test Plan:
- Reset, then idle for 5 cycles -> busy=0, done=0, result=0, alu_op=0 every cycle.
- start with a=3, b=5 -> states CHECK,SHR,ADD,SHL, CHECK,SHR,SHL, CHECK,SHR,ADD,SHL, CHECK, DONE. done is high 13 cycles after the start edge; result=15; alu_op sequence matches 01,45,00,65,...
- a=7, b=0 -> CHECK sees f=1; done on the 2nd cycle after start; result=0; ADD never issued.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> result=32'h00000001 after 32 iterations with 32 ADDs. With EARLY_EXIT=0 and b=1, iter reaches 32 before DONE; result=a.
- Pulse start again while busy with a=9, b=9 -> ignored; the original product completes unchanged; a new start in IDLE is then accepted normally.
- Assert rst in the ADD state of a 3x5 run -> same-cycle return to IDLE with all outputs 0; a subsequent 6x7 yields 42.

Source files
------------

// File: rtl/mcpu_alu_mul_seq.sv
// Shift-and-add multiply sequencer: drives an external MCPU ALU to form the
// low 32 bits of an unsigned 32x32 product, one multiplier bit per iteration.
module mcpu_alu_mul_seq #(
    parameter int unsigned MAX_ITER   = 32,
    parameter bit          EARLY_EXIT = 1'b1,
    localparam int unsigned W         = 32,
    localparam int unsigned IW        = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_d,
    input  logic         alu_f
);

    // ALU op words: AND/test B==0, OP_B>>1/test B_LO, ADD, OP_B<<1
    localparam logic [W-1:0] OP_CHECK = W'(32'h01);
    localparam logic [W-1:0] OP_SHR   = W'(32'h45);
    localparam logic [W-1:0] OP_ADD   = W'(32'h00);
    localparam logic [W-1:0] OP_SHL   = W'(32'h65);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHR,
        S_ADD,
        S_SHL,
        S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [IW-1:0] iter;
    logic [IW-1:0] iter_inc;

    assign iter_inc = iter + IW'(1);

    // Sequencer: ALU results are consumed at the edge that ends each state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            iter   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a_in;
                        mplier <= b_in;
                        acc    <= '0;
                        iter   <= '0;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    state <= (EARLY_EXIT && alu_f) ? S_DONE : S_SHR;
                end
                S_SHR: begin
                    // alu_f carries the bit shifted out of the multiplier
                    mplier <= alu_d;
                    state  <= alu_f ? S_ADD : S_SHL;
                end
                S_ADD: begin
                    acc   <= alu_d;
                    state <= S_SHL;
                end
                S_SHL: begin
                    mcand <= alu_d;
                    iter  <= iter_inc;
                    state <= (iter_inc == IW'(MAX_ITER)) ? S_DONE : S_CHECK;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ALU drive decoded from the current state and working registers
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            S_CHECK: begin
                alu_op = OP_CHECK;
                alu_b  = mplier;
            end
            S_SHR: begin
                alu_op = OP_SHR;
                alu_b  = mplier;
            end
            S_ADD: begin
                alu_op = OP_ADD;
                alu_a  = acc;
                alu_b  = mcand;
            end
            S_SHL: begin
                alu_op = OP_SHL;
                alu_b  = mcand;
            end
            default: begin
                alu_op = '0;
            end
        endcase
    end

    // Status outputs decode the state register directly
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign result = acc;

endmodule

// File: tb/tb_mcpu_alu_mul_seq.sv
// Bench for mcpu_alu_mul_seq: ALU model, per-cycle reference model, directed runs.
module tb_mcpu_alu_mul_seq;

    typedef struct packed {
        logic [31:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic        done;
        logic [31:0] res;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic        busy, done, alu_f;
    logic [31:0] result, alu_op, alu_a, alu_b, alu_d;
    logic        busy2, done2, alu_f2;
    logic [31:0] result2, alu_op2, alu_a2, alu_b2, alu_d2;

    int total = 0;
    int bad   = 0;

    rec_t        exp_q[$];
    logic [31:0] exp_result = '0;
    logic [31:0] op_log[$];
    logic [31:0] exp_ops[13] = '{32'h01, 32'h45, 32'h00, 32'h65, 32'h01, 32'h45, 32'h65,
                                 32'h01, 32'h45, 32'h00, 32'h65, 32'h01, 32'h00};

    logic        s_done, s_done2;
    logic [31:0] s_op, s_res, s_res2;

    always #5 clk = ~clk;

    // External ALU: {flag, data} as a combinational function of op/a/b
    function automatic logic [32:0] alu_model(input logic [31:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] bv;
        logic [31:0] d;
        logic        f;
        case (op[6:5])
            2'd2:    bv = b >> 1;
            2'd3:    bv = b << 1;
            default: bv = b;
        endcase
        case (op[2:0])
            3'd0:    d = a + bv;
            3'd1:    d = a & bv;
            3'd5:    d = bv;
            default: d = '0;
        endcase
        case (op[2:0])
            3'd1:    f = (b == 32'h0);
            3'd5:    f = b[0];
            default: f = 1'b0;
        endcase
        return {f, d};
    endfunction

    assign {alu_f, alu_d}   = alu_model(alu_op, alu_a, alu_b);
    assign {alu_f2, alu_d2} = alu_model(alu_op2, alu_a2, alu_b2);

    mcpu_alu_mul_seq #(.MAX_ITER(32), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d), .alu_f(alu_f)
    );

    mcpu_alu_mul_seq #(.MAX_ITER(32), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .rst(rst), .start(start2), .a_in(a_in), .b_in(b_in),
        .busy(busy2), .done(done2), .result(result2),
        .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_d(alu_d2), .alu_f(alu_f2)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected per-cycle ALU traffic of the multiply routine (early-exit variant)
    function automatic void build(input logic [31:0] a, input logic [31:0] b, output rec_t q[$]);
        logic [31:0] acc;
        logic [31:0] mc;
        logic [31:0] m;
        q.delete();
        acc = '0;
        mc  = a;
        m   = b;
        for (int i = 0; i < 32; i++) begin
            if (m == 0) begin
                q.push_back('{32'h01, 32'h0, m, 1'b0, 32'h0});
                break;
            end
            q.push_back('{32'h01, 32'h0, m, 1'b0, 32'h0});
            q.push_back('{32'h45, 32'h0, m, 1'b0, 32'h0});
            if (m[0]) begin
                q.push_back('{32'h00, acc, mc, 1'b0, 32'h0});
                acc = acc + mc;
            end
            q.push_back('{32'h65, 32'h0, mc, 1'b0, 32'h0});
            mc = mc << 1;
            m  = m >> 1;
        end
        q.push_back('{32'h0, 32'h0, 32'h0, 1'b1, a * b});
    endfunction

    // Per-cycle comparison of the early-exit DUT against the reference model
    task automatic model_check();
        rec_t r;
        s_op    = alu_op;
        s_done  = done;
        s_res   = result;
        s_done2 = done2;
        s_res2  = result2;
        if (rst) begin
            check("reset outputs", {busy, done, alu_op, alu_a, alu_b, result}, '0);
            exp_q.delete();
            exp_result = '0;
        end else if (exp_q.size() == 0) begin
            check("idle outputs", {busy, done, alu_op, alu_a, alu_b, result},
                  {2'b00, 96'h0, exp_result});
            if (start) build(a_in, b_in, exp_q);
        end else begin
            r = exp_q.pop_front();
            check("busy drive", {busy, done, alu_op, alu_a, alu_b},
                  {1'b1, r.done, r.op, r.a, r.b});
            if (r.done) begin
                check("done result", result, r.res);
                exp_result = r.res;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    // Start one multiply, optionally poke start while busy, and time the done pulse
    task automatic run_op(input string name, input bit sel2, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input bit poke);
        int          lat;
        logic [31:0] res;
        lat = -1;
        res = '0;
        op_log.delete();
        a_in = a;
        b_in = b;
        if (sel2) start2 = 1'b1;
        else start = 1'b1;
        step();
        start  = 1'b0;
        start2 = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (poke && (k == 3 || k == exp_lat)) begin
                start = 1'b1;
                a_in  = 32'd9;
                b_in  = 32'd9;
            end else begin
                start = 1'b0;
            end
            step();
            op_log.push_back(s_op);
            if (sel2 ? s_done2 : s_done) begin
                lat = k;
                res = sel2 ? s_res2 : s_res;
                break;
            end
        end
        start = 1'b0;
        check({name, " latency"}, 160'(lat), 160'(exp_lat));
        check({name, " result"}, res, exp_res);
    endtask

    initial begin
        rec_t tq[$];

        // Pin the reference model with hand-derived numbers
        build(32'd3, 32'd5, tq);
        check("model 3x5 cycles", 160'(tq.size()), 160'(13));
        check("model 3x5 product", tq[tq.size()-1].res, 32'd15);
        build(32'hFFFFFFFF, 32'hFFFFFFFF, tq);
        check("model ffx ff cycles", 160'(tq.size()), 160'(129));
        check("model ffx ff product", tq[tq.size()-1].res, 32'd1);

        step();
        step();
        rst = 1'b0;
        repeat (5) step();

        run_op("3x5", 1'b0, 32'd3, 32'd5, 13, 32'd15, 1'b0);
        for (int i = 0; i < 13; i++) begin
            if (i < op_log.size()) check("3x5 op sequence", op_log[i], exp_ops[i]);
            else check("3x5 op sequence length", 160'(op_log.size()), 160'(13));
        end

        run_op("7x0", 1'b0, 32'd7, 32'd0, 2, 32'd0, 1'b0);
        check("7x0 no add issued", 160'(op_log.size()), 160'(2));

        run_op("ffx ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 129, 32'h1, 1'b0);
        run_op("11x6 start while busy", 1'b0, 32'd11, 32'd6, 13, 32'd66, 1'b1);
        run_op("9x9", 1'b0, 32'd9, 32'd9, 16, 32'd81, 1'b0);

        // Reset asserted while in the ADD state of a 3x5 run
        a_in  = 32'd3;
        b_in  = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("in ADD before reset", {busy, alu_op, alu_a, alu_b}, {1'b1, 32'h0, 32'h0, 32'd3});
        rst = 1'b1;
        #1;
        check("reset same cycle", {busy, done, alu_op, alu_a, alu_b, result}, '0);
        step();
        rst = 1'b0;
        step();

        run_op("6x7 after reset", 1'b0, 32'd6, 32'd7, 14, 32'd42, 1'b0);
        run_op("no early exit b=1", 1'b1, 32'h12345678, 32'd1, 98, 32'h12345678, 1'b0);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
